dm_bus_arbiter: RTL and testbench

Two-master round-robin arbiter for the debug module's single slave bus port (slave_req/we/addr/be/wdata/rdata on dm_top). Shares the port between the core's instruction-fetch master (read-only) and data master (read/write). Routes the one-cycle-latency read data back to the master that issued the request. Requests outside the debug window are terminated locally with an error response and never reach dm_top.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_bus_arbiter_rr_arb2.sv | 24 ++
 rtl/dm_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_dm_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the debug-module slave-port arbiter.
package dm_arb_pkg;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Window is a power-of-two size aligned to its base, so a masked compare of
  // the upper address bits is sufficient.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    logic [63:0] mask;
    mask = ~(size - 64'd1);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/dm_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker; index 0 is the fetch master, index 1 the data master.
module dm_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt,
  output logic       rr_ptr_next
);

  always_comb begin
    gnt         = '0;
    rr_ptr_next = rr_ptr;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Under contention the pointer names the winner, then moves to the loser.
        gnt         = rr_ptr ? 2'b10 : 2'b01;
        rr_ptr_next = ~rr_ptr;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Shares the debug module's single slave port between fetch and data masters,
// terminating out-of-window requests locally with an error response.
module dm_bus_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned           BusWidth      = 32,
  parameter logic [BusWidth-1:0]   DmBaseAddress = 'h1000,
  parameter int unsigned           DmWindowSize  = 'h1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  i_req_i,
  input  logic [BusWidth-1:0]   i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [BusWidth-1:0]   i_rdata_o,
  output logic                  i_err_o,

  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [BusWidth-1:0]   d_addr_i,
  input  logic [BusWidth-1:0]   d_wdata_i,
  input  logic [BusWidth/8-1:0] d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic                  d_err_o,
  output logic [BusWidth-1:0]   d_rdata_o,

  output logic                  slave_req_o,
  output logic                  slave_we_o,
  output logic [BusWidth-1:0]   slave_addr_o,
  output logic [BusWidth-1:0]   slave_wdata_o,
  output logic [BusWidth/8-1:0] slave_be_o,
  input  logic [BusWidth-1:0]   slave_rdata_i
);

  localparam int unsigned BeWidth = BusWidth / 8;

  logic [1:0]          arb_req;
  logic [1:0]          arb_gnt;
  logic                rr_ptr_q;
  logic                rr_ptr_next;

  owner_e              win_owner;
  logic                win_we;
  logic [BusWidth-1:0] win_addr;
  logic [BusWidth-1:0] win_wdata;
  logic [BeWidth-1:0]  win_be;
  logic                win_in_window;
  logic                any_gnt;
  logic                fwd;

  logic                resp_valid_q;
  owner_e              resp_owner_q;
  logic                resp_err_q;
  logic                resp_we_q;
  logic                resp_live;
  logic [BusWidth-1:0] resp_data;

  assign arb_req = {d_req_i, i_req_i};

  dm_rr_arb2 u_rr_arb2 (
    .req         (arb_req),
    .rr_ptr      (rr_ptr_q),
    .gnt         (arb_gnt),
    .rr_ptr_next (rr_ptr_next)
  );

  always_comb begin
    win_owner = OWNER_I;
    win_we    = 1'b0;
    win_addr  = i_addr_i;
    win_wdata = '0;
    win_be    = '1;
    if (arb_gnt[1]) begin
      win_owner = OWNER_D;
      win_we    = d_we_i;
      win_addr  = d_addr_i;
      win_wdata = d_wdata_i;
      win_be    = d_be_i;
    end
  end

  assign win_in_window = in_window(64'(win_addr), 64'(DmBaseAddress), 64'(DmWindowSize));
  assign any_gnt       = rst_ni && (|arb_gnt);
  assign fwd           = any_gnt && win_in_window;

  assign i_gnt_o = rst_ni && arb_gnt[0];
  assign d_gnt_o = rst_ni && arb_gnt[1];

  assign slave_req_o   = fwd;
  assign slave_we_o    = fwd && win_we;
  assign slave_addr_o  = fwd ? win_addr  : '0;
  assign slave_wdata_o = fwd ? win_wdata : '0;
  assign slave_be_o    = fwd ? win_be    : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWNER_I;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_next;
      resp_valid_q <= any_gnt;
      if (any_gnt) begin
        resp_owner_q <= win_owner;
        resp_err_q   <= !win_in_window;
        resp_we_q    <= win_we;
      end
    end
  end

  // Only in-window reads carry slave data; write acks and errors return zero.
  assign resp_live = rst_ni && resp_valid_q;
  assign resp_data = (resp_err_q || resp_we_q) ? '0 : slave_rdata_i;

  assign i_rvalid_o = resp_live && (resp_owner_q == OWNER_I);
  assign i_err_o    = i_rvalid_o && resp_err_q;
  assign i_rdata_o  = i_rvalid_o ? resp_data : '0;

  assign d_rvalid_o = resp_live && (resp_owner_q == OWNER_D);
  assign d_err_o    = d_rvalid_o && resp_err_q;
  assign d_rdata_o  = d_rvalid_o ? resp_data : '0;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: vector table for grants/forwarding,
// scoreboard queue for the one-cycle-later responses.
module tb_dm_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        slave_req_o, slave_we_o;
  logic [31:0] slave_addr_o, slave_wdata_o;
  logic [3:0]  slave_be_o;
  logic [31:0] slave_rdata_i = 32'h0;

  always #5 clk = ~clk;

  dm_bus_arbiter #(
    .BusWidth      (32),
    .DmBaseAddress (32'h1000),
    .DmWindowSize  (32'h1000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .i_req_i       (i_req_i),
    .i_addr_i      (i_addr_i),
    .i_gnt_o       (i_gnt_o),
    .i_rvalid_o    (i_rvalid_o),
    .i_rdata_o     (i_rdata_o),
    .i_err_o       (i_err_o),
    .d_req_i       (d_req_i),
    .d_we_i        (d_we_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_be_i        (d_be_i),
    .d_gnt_o       (d_gnt_o),
    .d_rvalid_o    (d_rvalid_o),
    .d_err_o       (d_err_o),
    .d_rdata_o     (d_rdata_o),
    .slave_req_o   (slave_req_o),
    .slave_we_o    (slave_we_o),
    .slave_addr_o  (slave_addr_o),
    .slave_wdata_o (slave_wdata_o),
    .slave_be_o    (slave_be_o),
    .slave_rdata_i (slave_rdata_i)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [1:0]  exp_gnt;   // {d, i}
    logic        exp_sreq;
  } vec_t;

  typedef struct {
    logic        owner;     // 0 = fetch, 1 = data
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[18];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [31:0] slave_fn(input logic [31:0] a);
    return (a == 32'h1800) ? 32'h0010_0073 : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic tb_in_win(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h2000);
  endfunction

  // dm_top stand-in: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (slave_req_o && !slave_we_o) slave_rdata_i <= slave_fn(slave_addr_o);
    else                            slave_rdata_i <= 32'hBAD0_0000 ^ $urandom_range(0, 65535);
  end

  function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] dd, input logic [3:0] db,
                              input logic [1:0] g, input logic sr);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dd; v.d_be = db; v.exp_gnt = g; v.exp_sreq = sr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input string tag);
    resp_t       e;
    logic        iv, dv, ie, de;
    logic [31:0] ird, drd;
    iv = 0; dv = 0; ie = 0; de = 0; ird = '0; drd = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.owner) begin dv = 1; de = e.err; drd = e.rdata; end
      else         begin iv = 1; ie = e.err; ird = e.rdata; end
    end
    chk({tag, " i_rvalid"}, 32'(i_rvalid_o), 32'(iv));
    chk({tag, " i_err"},    32'(i_err_o),    32'(ie));
    chk({tag, " i_rdata"},  i_rdata_o,       ird);
    chk({tag, " d_rvalid"}, 32'(d_rvalid_o), 32'(dv));
    chk({tag, " d_err"},    32'(d_err_o),    32'(de));
    chk({tag, " d_rdata"},  d_rdata_o,       drd);
  endtask

  task automatic drive(input vec_t v);
    i_req_i = v.i_req; i_addr_i = v.i_addr;
    d_req_i = v.d_req; d_we_i = v.d_we; d_addr_i = v.d_addr;
    d_wdata_i = v.d_wdata; d_be_i = v.d_be;
  endtask

  task automatic apply(input vec_t v, input string tag);
    resp_t       r;
    logic        is_d, we;
    logic [31:0] addr;
    @(negedge clk);
    check_resp({tag, " resp"});
    drive(v);
    #1;
    chk({tag, " gnt"},      32'({d_gnt_o, i_gnt_o}), 32'(v.exp_gnt));
    chk({tag, " slv_req"},  32'(slave_req_o),        32'(v.exp_sreq));
    if (v.exp_gnt != 2'b00) begin
      is_d = v.exp_gnt[1];
      addr = is_d ? v.d_addr : v.i_addr;
      we   = is_d ? v.d_we : 1'b0;
      if (v.exp_sreq) begin
        chk({tag, " slv_addr"}, slave_addr_o,      addr);
        chk({tag, " slv_we"},   32'(slave_we_o),   32'(we));
        chk({tag, " slv_be"},   32'(slave_be_o),   is_d ? 32'(v.d_be) : 32'hF);
        if (is_d) chk({tag, " slv_wdata"}, slave_wdata_o, v.d_wdata);
      end
      r.owner = is_d;
      r.err   = !tb_in_win(addr);
      r.rdata = (!r.err && !we) ? slave_fn(addr) : 32'h0;
      sb.push_back(r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 2'b00, 0);
    vecs[1]  = mk(1, 32'h1800, 0, 0, 32'h0,    32'h0,        4'h0, 2'b01, 1);
    vecs[2]  = mk(1, 32'h1804, 1, 0, 32'h1200, 32'h0,        4'hF, 2'b01, 1);
    vecs[3]  = mk(1, 32'h1804, 1, 0, 32'h1200, 32'h0,        4'hF, 2'b10, 1);
    vecs[4]  = mk(1, 32'h1808, 1, 0, 32'h1204, 32'h0,        4'hF, 2'b01, 1);
    vecs[5]  = mk(1, 32'h180C, 1, 0, 32'h1204, 32'h0,        4'hF, 2'b10, 1);
    vecs[6]  = mk(0, 32'h0,    1, 1, 32'h1100, 32'hDEADBEEF, 4'h3, 2'b10, 1);
    vecs[7]  = mk(0, 32'h0,    1, 0, 32'h2000, 32'h0,        4'hF, 2'b10, 0);
    vecs[8]  = mk(1, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 2'b01, 0);
    vecs[9]  = mk(0, 32'h0,    1, 0, 32'h1FFC, 32'h0,        4'hF, 2'b10, 1);
    vecs[10] = mk(0, 32'h0,    1, 0, 32'h0FFC, 32'h0,        4'hF, 2'b10, 0);
    vecs[11] = mk(1, 32'h2000, 1, 1, 32'h1000, 32'h1234_5678, 4'hF, 2'b01, 0);
    vecs[12] = mk(1, 32'h2000, 1, 1, 32'h1000, 32'h1234_5678, 4'hF, 2'b10, 1);
    vecs[13] = mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 2'b00, 0);
    vecs[14] = mk(1, 32'h1010, 1, 0, 32'h1020, 32'h0,        4'hC, 2'b01, 1);
    vecs[15] = mk(0, 32'h1010, 1, 0, 32'h1020, 32'h0,        4'hC, 2'b10, 1);
    vecs[16] = mk(1, 32'h1030, 1, 0, 32'h1040, 32'h0,        4'h5, 2'b10, 1);
    vecs[17] = mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 2'b00, 0);

    // Reset with both masters requesting: everything forced quiet.
    rst_ni = 1'b0;
    drive(mk(1, 32'h1800, 1, 1, 32'h1100, 32'hFFFF_FFFF, 4'hF, 2'b00, 0));
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst gnt",      32'({d_gnt_o, i_gnt_o}), 32'h0);
    chk("rst slv_req",  32'(slave_req_o),        32'h0);
    chk("rst slv_addr", slave_addr_o,            32'h0);
    chk("rst slv_data", slave_wdata_o,           32'h0);
    chk("rst rvalid",   32'({d_rvalid_o, i_rvalid_o}), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(vecs[0]);

    for (int i = 0; i < 18; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Leave rr_ptr pointing at data, then reset during the response cycle.
    apply(mk(1, 32'h1800, 1, 0, 32'h1204, 32'h0, 4'hF, 2'b01, 1), "rs0");
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("rs1 i_rvalid", 32'(i_rvalid_o), 32'h0);
    chk("rs1 d_rvalid", 32'(d_rvalid_o), 32'h0);
    chk("rs1 i_rdata",  i_rdata_o,       32'h0);
    chk("rs1 gnt",      32'({d_gnt_o, i_gnt_o}), 32'h0);
    chk("rs1 slv_req",  32'(slave_req_o), 32'h0);
    sb.delete();
    @(negedge clk);
    drive(vecs[0]);
    @(negedge clk);
    rst_ni = 1'b1;
    apply(mk(1, 32'h1808, 1, 0, 32'h1208, 32'h0, 4'hF, 2'b01, 1), "rs2");
    apply(mk(1, 32'h180C, 1, 0, 32'h1208, 32'h0, 4'hF, 2'b10, 1), "rs3");
    apply(vecs[17], "rs4");
    @(negedge clk);
    check_resp("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
